// File: rtl/exception_unit_if.sv
// -----------------------------------------------------------------------------
// exception_unit_if
// Bundles the pipeline-side exception requests, the CSR-side handshake and the
// fetch redirect handshake of the trap sequencer.
//   master : pipeline / CSR / fetch side (drives requests, observes results)
//   slave  : exception_unit (observes requests, drives results)
// Signals:
//   id_illegal, id_ecall, id_pc          decode-stage requests and PC
//   ex_misaligned_fetch, ex_pc           execute-stage request and PC
//   mem_load_misaligned,
//   mem_store_misaligned, mem_pc         memory-stage requests and PC
//   mret_req, epc                        mret commit and saved EPC
//   pipe_drained                         all stages empty after flush
//   redirect_ready                       fetch accepted redirect
//   exception_sig, exception_pc,
//   exception_cause                      one-cycle CSR write strobe and data
//   flush                                kill in-flight instructions
//   redirect_valid, redirect_pc          redirect request to fetch
//   in_trap                              trap handler active
// -----------------------------------------------------------------------------
interface exception_unit_if;
    logic        id_illegal;
    logic        id_ecall;
    logic [31:0] id_pc;
    logic        ex_misaligned_fetch;
    logic [31:0] ex_pc;
    logic        mem_load_misaligned;
    logic        mem_store_misaligned;
    logic [31:0] mem_pc;
    logic        mret_req;
    logic [31:0] epc;
    logic        pipe_drained;
    logic        redirect_ready;
    logic        exception_sig;
    logic [31:0] exception_pc;
    logic [4:0]  exception_cause;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        in_trap;

    modport master (
        output id_illegal, id_ecall, id_pc,
        output ex_misaligned_fetch, ex_pc,
        output mem_load_misaligned, mem_store_misaligned, mem_pc,
        output mret_req, epc, pipe_drained, redirect_ready,
        input  exception_sig, exception_pc, exception_cause,
        input  flush, redirect_valid, redirect_pc, in_trap
    );

    modport slave (
        input  id_illegal, id_ecall, id_pc,
        input  ex_misaligned_fetch, ex_pc,
        input  mem_load_misaligned, mem_store_misaligned, mem_pc,
        input  mret_req, epc, pipe_drained, redirect_ready,
        output exception_sig, exception_pc, exception_cause,
        output flush, redirect_valid, redirect_pc, in_trap
    );
endinterface

// File: rtl/exception_unit.sv
// -----------------------------------------------------------------------------
// exception_unit
// Trap sequencer between the pipeline stages and the CSR block. Picks the
// oldest pending exception, writes its PC/cause to the CSRs with a one-cycle
// strobe, flushes the pipeline and redirects fetch to TRAP_VECTOR. Also
// redirects fetch to the saved EPC on mret.
// Parameters:
//   TRAP_VECTOR  fetch target on any exception
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   bus          exception_unit_if.slave (requests in, CSR/flush/redirect out)
// Build option:
//   EXC_DOUBLE_FAULT_EN  when defined, an exception taken while in_trap is set
//                        parks the unit in HALT with flush held until reset;
//                        when undefined, nested exceptions trap normally.
// -----------------------------------------------------------------------------
module exception_unit #(
    parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic                    clk,
    input  logic                    reset,
    exception_unit_if.slave         bus
);

    localparam logic [4:0] CAUSE_MISALIGNED_FETCH = 5'd0;
    localparam logic [4:0] CAUSE_ILLEGAL          = 5'd2;
    localparam logic [4:0] CAUSE_LOAD_MISALIGNED  = 5'd4;
    localparam logic [4:0] CAUSE_STORE_MISALIGNED = 5'd6;
    localparam logic [4:0] CAUSE_ECALL            = 5'd11;

`ifdef EXC_DOUBLE_FAULT_EN
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2,
        ST_HALT     = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLUSH    = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;
`endif

    state_t      state_r;
    logic        exception_sig_r;
    logic [31:0] exception_pc_r;
    logic [4:0]  exception_cause_r;
    logic        flush_r;
    logic        redirect_valid_r;
    logic [31:0] redirect_pc_r;
    logic        in_trap_r;
    logic        mret_redirect_r;   // current redirect returns from the handler

    logic        req_any_s;
    logic [31:0] req_pc_s;
    logic [4:0]  req_cause_s;

    // Oldest-stage-first selection; younger requests are dropped since the flush kills them
    always_comb begin
        req_any_s   = 1'b1;
        req_pc_s    = 32'd0;
        req_cause_s = 5'd0;
        if (bus.mem_load_misaligned) begin
            req_pc_s    = bus.mem_pc;
            req_cause_s = CAUSE_LOAD_MISALIGNED;
        end else if (bus.mem_store_misaligned) begin
            req_pc_s    = bus.mem_pc;
            req_cause_s = CAUSE_STORE_MISALIGNED;
        end else if (bus.ex_misaligned_fetch) begin
            req_pc_s    = bus.ex_pc;
            req_cause_s = CAUSE_MISALIGNED_FETCH;
        end else if (bus.id_illegal) begin
            req_pc_s    = bus.id_pc;
            req_cause_s = CAUSE_ILLEGAL;
        end else if (bus.id_ecall) begin
            req_pc_s    = bus.id_pc;
            req_cause_s = CAUSE_ECALL;
        end else begin
            req_any_s   = 1'b0;
        end
    end

    // Trap sequencer FSM with all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r           <= ST_IDLE;
            exception_sig_r   <= 1'b0;
            exception_pc_r    <= 32'd0;
            exception_cause_r <= 5'd0;
            flush_r           <= 1'b0;
            redirect_valid_r  <= 1'b0;
            redirect_pc_r     <= 32'd0;
            in_trap_r         <= 1'b0;
            mret_redirect_r   <= 1'b0;
        end else begin
            // CSR strobe is a single-cycle pulse
            exception_sig_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
`ifdef EXC_DOUBLE_FAULT_EN
                    // Fault inside the handler: no CSR update, park with flush held
                    if (req_any_s && in_trap_r) begin
                        flush_r <= 1'b1;
                        state_r <= ST_HALT;
                    end else
`endif
                    if (req_any_s) begin
                        // Exception wins over a same-cycle mret
                        exception_sig_r   <= 1'b1;
                        exception_pc_r    <= req_pc_s;
                        exception_cause_r <= req_cause_s;
                        in_trap_r         <= 1'b1;
                        flush_r           <= 1'b1;
                        redirect_pc_r     <= TRAP_VECTOR;
                        mret_redirect_r   <= 1'b0;
                        state_r           <= ST_FLUSH;
                    end else if (bus.mret_req) begin
                        redirect_pc_r     <= bus.epc;
                        redirect_valid_r  <= 1'b1;
                        mret_redirect_r   <= 1'b1;
                        state_r           <= ST_REDIRECT;
                    end else begin
                        state_r           <= ST_IDLE;
                    end
                end
                ST_FLUSH: begin
                    if (bus.pipe_drained) begin
                        flush_r          <= 1'b0;
                        redirect_valid_r <= 1'b1;
                        state_r          <= ST_REDIRECT;
                    end else begin
                        flush_r          <= 1'b1;
                    end
                end
                ST_REDIRECT: begin
                    if (bus.redirect_ready) begin
                        redirect_valid_r <= 1'b0;
                        if (mret_redirect_r) begin
                            in_trap_r <= 1'b0;
                        end else begin
                            in_trap_r <= in_trap_r;
                        end
                        mret_redirect_r  <= 1'b0;
                        state_r          <= ST_IDLE;
                    end else begin
                        redirect_valid_r <= 1'b1;
                    end
                end
`ifdef EXC_DOUBLE_FAULT_EN
                ST_HALT: begin
                    flush_r <= 1'b1;
                    state_r <= ST_HALT;
                end
`endif
                default: begin
                    flush_r          <= 1'b0;
                    redirect_valid_r <= 1'b0;
                    mret_redirect_r  <= 1'b0;
                    state_r          <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.exception_sig   = exception_sig_r;
    assign bus.exception_pc    = exception_pc_r;
    assign bus.exception_cause = exception_cause_r;
    assign bus.flush           = flush_r;
    assign bus.redirect_valid  = redirect_valid_r;
    assign bus.redirect_pc     = redirect_pc_r;
    assign bus.in_trap         = in_trap_r;

endmodule

// File: doc/exception_unit.md
# exception_unit

Trap sequencer between the pipeline stages and the CSR block. It collects exception requests from decode, execute and memory, and picks the oldest one. It then records the trapping PC and cause into the CSR block with a one-cycle write pulse, flushes the pipeline, and redirects fetch to the trap vector. It also handles `mret`, redirecting fetch to the saved EPC.

## Interface
- `TRAP_VECTOR`, default 32'h0000_0100: fetch target on any exception.
- `clk` input 1: system clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `id_illegal`, `id_ecall` input 1 each: decode-stage exception requests.
- `id_pc` input 32: PC of the decode-stage instruction.
- `ex_misaligned_fetch` input 1: execute-stage branch/jump target misaligned.
- `ex_pc` input 32: PC of the execute-stage instruction.
- `mem_load_misaligned`, `mem_store_misaligned` input 1 each: memory-stage exception requests.
- `mem_pc` input 32: PC of the memory-stage instruction.
- `mret_req` input 1: `mret` committed.
- `epc` input 32: EPC value from the CSR block.
- `pipe_drained` input 1: all stages are empty after the flush.
- `redirect_ready` input 1: fetch accepted the redirect.
- `exception_sig` output 1: one-cycle CSR write strobe.
- `exception_pc` output 32: PC written to the CSR EPC register.
- `exception_cause` output 5: cause written to the CSR cause register.
- `flush` output 1: kill all in-flight instructions.
- `redirect_valid` output 1: redirect request to fetch.
- `redirect_pc` output 32: redirect target.
- `in_trap` output 1: handler is active (set on exception, cleared on `mret` redirect).

## Operation
- Cause codes: misaligned fetch = 0, illegal = 2, load misaligned = 4, store misaligned = 6, ecall = 11.
- Priority, oldest stage first:
  - mem load, then mem store;
  - ex misaligned fetch;
  - id illegal, then id ecall.
- Only the highest-priority request is taken. All others in the same cycle are discarded because they will be flushed.
- FSM states: IDLE, FLUSH, REDIRECT, HALT (HALT exists only when configured).
- IDLE:
  - Any request: latch pc and cause, pulse `exception_sig`, set `in_trap`, go to FLUSH with target = `TRAP_VECTOR`.
  - Otherwise `mret_req`: latch target = `epc`, go to REDIRECT.
  - A request and `mret_req` in the same cycle: the exception wins and `mret_req` is dropped.
- FLUSH: hold `flush` high. When `pipe_drained` is sampled high, go to REDIRECT.
- REDIRECT: hold `redirect_valid` high with a stable `redirect_pc`. When `redirect_ready` is sampled high, go to IDLE. If the redirect was for `mret`, clear `in_trap` on that cycle.
- In FLUSH, REDIRECT and HALT, all exception requests and `mret_req` are ignored.
- `exception_pc` and `exception_cause` hold their last values between events.

## Timing
- Reset values:
  - state = IDLE;
  - `exception_sig`, `flush`, `redirect_valid`, `in_trap` = 0;
  - `exception_pc`, `redirect_pc` = 0;
  - `exception_cause` = 0.
- All outputs are registered.
- Request sampled at edge N:
  - `exception_sig` is high for exactly the cycle after N, with `exception_pc`/`exception_cause` valid that same cycle;
  - `flush` rises in that same cycle.
- `pipe_drained` already high on the first FLUSH cycle: `flush` is high for exactly one cycle, and `redirect_valid` rises the next cycle.
- `mret_req` sampled at edge N: `redirect_valid` is high in cycle N+1. No `exception_sig`, no `flush`.
- `redirect_valid` stays high until the edge at which `redirect_ready` is high, and falls the following cycle.
- Minimum exception-to-redirect latency is 2 cycles. The block is back-to-back capable: a new request can be accepted in the first IDLE cycle.
- Reset asserted mid-sequence: all state returns to reset values immediately, with no pulse and no redirect.

## Configuration
- `EXC_DOUBLE_FAULT_EN`:
  - Defined: an exception request in IDLE while `in_trap` = 1 goes to HALT, with no `exception_sig` and no CSR update. HALT asserts `flush` permanently. Only reset exits HALT.
  - Undefined: HALT is not built. Nested exceptions are handled normally and overwrite EPC/cause.

## Test plan
- `mem_load_misaligned`=1 with `mem_pc`=0x40 and `id_illegal`=1 in the same cycle -> one `exception_sig` pulse, pc=0x40, cause=4; `flush` held until `pipe_drained`; `redirect_pc`=0x100.
- `id_ecall` with `id_pc`=0x20, `pipe_drained` already high, `redirect_ready` held low 3 cycles -> `flush` high 1 cycle; `redirect_valid` high 4 cycles, stable at 0x100.
- `mret_req` with `epc`=0x24 while `in_trap`=1 -> `redirect_pc`=0x24, no `exception_sig`, `in_trap` clears on handshake.
- `mret_req` and `ex_misaligned_fetch` (`ex_pc`=0x30) in the same cycle -> exception taken, cause=0, pc=0x30; mret dropped.
- Reset asserted during FLUSH -> `flush`, `redirect_valid`, `in_trap` all 0 immediately; a new `id_illegal` after reset gives a normal trap with cause=2.
- `EXC_DOUBLE_FAULT_EN` defined: trap, then `id_illegal` before `mret` -> no second `exception_sig`; `flush` stuck high until reset.
